p_layer_seq: RTL and testbench



---
 rtl/p_table_pkg.sv | 72 +++++++
 rtl/p_module.sv | 28 ++
 rtl/p_layer_seq.sv | 128 ++++++++++++
 tb/tb_p_layer_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/p_table_pkg.sv
// -----------------------------------------------------------------------------
// p_table_pkg
//   Shared definitions for the CS-Cipher P-layer blocks.
//   - p_seq_state_t : state encoding of the time-multiplexed P-layer sequencer
//   - p_f / p_g     : 4-bit nonlinear boxes used by the P permutation
//   - p_lookup      : behavioural 8-bit P permutation (reference model)
//
//   P is a three-round nibble Feistel structure, so it is a bijection on 8 bits
//   whatever the contents of the f and g boxes:
//     c = f(xl) ^ xr ;  d = g(c) ^ xl ;  e = f(d) ^ c ;  P(x) = {d, e}
// -----------------------------------------------------------------------------
package p_table_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } p_seq_state_t;

    function automatic logic [3:0] p_f(input logic [3:0] x);
        case (x)
            4'h0:    return 4'hF;
            4'h1:    return 4'hD;
            4'h2:    return 4'hB;
            4'h3:    return 4'hB;
            4'h4:    return 4'h7;
            4'h5:    return 4'h5;
            4'h6:    return 4'h7;
            4'h7:    return 4'h7;
            4'h8:    return 4'hE;
            4'h9:    return 4'hD;
            4'hA:    return 4'hA;
            4'hB:    return 4'hB;
            4'hC:    return 4'hE;
            4'hD:    return 4'hD;
            4'hE:    return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] p_g(input logic [3:0] x);
        case (x)
            4'h0:    return 4'hA;
            4'h1:    return 4'h6;
            4'h2:    return 4'h0;
            4'h3:    return 4'h2;
            4'h4:    return 4'hB;
            4'h5:    return 4'hE;
            4'h6:    return 4'h1;
            4'h7:    return 4'h8;
            4'h8:    return 4'hD;
            4'h9:    return 4'h4;
            4'hA:    return 4'h5;
            4'hB:    return 4'h3;
            4'hC:    return 4'hF;
            4'hD:    return 4'hC;
            4'hE:    return 4'h7;
            default: return 4'h9;
        endcase
    endfunction

    function automatic logic [7:0] p_lookup(input logic [7:0] x);
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] e;
        c = p_f(x[7:4]) ^ x[3:0];
        d = p_g(c) ^ x[7:4];
        e = p_f(d) ^ c;
        return {d, e};
    endfunction

endpackage

// File: rtl/p_module.sv
// -----------------------------------------------------------------------------
// p_module
//   Combinational 8-bit CS-Cipher P permutation (one lane of the P layer).
//   Ports:
//     x : input byte
//     y : P(x)
//   The f and g boxes are held as packed nibble tables, entry i at [4*i +: 4].
// -----------------------------------------------------------------------------
module p_module (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [63:0] F_VEC = 64'hFEDEBADE7757BBDF;
    localparam logic [63:0] G_VEC = 64'h97CF354D81EB206A;

    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] e;

    always_comb begin
        c = F_VEC[{x[7:4], 2'b00} +: 4] ^ x[3:0];
        d = G_VEC[{c, 2'b00} +: 4] ^ x[7:4];
        e = F_VEC[{d, 2'b00} +: 4] ^ c;
        y = {d, e};
    end

endmodule

// File: rtl/p_layer_seq.sv
// -----------------------------------------------------------------------------
// p_layer_seq
//   Time-multiplexed CS-Cipher P layer. Every byte of an NBYTES-wide word goes
//   through the 8-bit P permutation using LANES parallel P units over
//   STEPS = NBYTES/LANES cycles. A per-word bypass passes bytes unchanged but
//   keeps the same latency.
//
//   Parameters:
//     NBYTES : bytes per word
//     LANES  : P units instantiated (>=1, must divide NBYTES)
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : synchronous active-low reset
//     in_valid  : input word valid
//     in_ready  : block can accept a word (combinational from state/out_ready)
//     in_data   : input word, byte i = in_data[8*i +: 8]
//     in_bypass : 1 = pass bytes unchanged (sampled with in_data)
//     out_valid : result valid, held until taken
//     out_ready : downstream accepts
//     out_data  : result word, byte i = P(in byte i) or in byte i if bypass
//     busy      : high while the word is being processed
// -----------------------------------------------------------------------------
module p_layer_seq
    import p_table_pkg::*;
#(
    parameter int NBYTES = 8,
    parameter int LANES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
    input  logic                  in_bypass,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data,
    output logic                  busy
);

    localparam int LANES_SAFE = (LANES < 1) ? 1 : LANES;
    localparam int STEPS      = NBYTES / LANES_SAFE;
    localparam int CNT_W      = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int W          = 8 * NBYTES;
    localparam int LW         = 8 * LANES_SAFE;

    if (LANES < 1 || (NBYTES % LANES_SAFE) != 0) begin : g_bad_cfg
        $fatal(1, "p_layer_seq: LANES must be >= 1 and divide NBYTES");
    end

    p_seq_state_t     state;
    p_seq_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     sr;
    logic             byp;
    logic [LW-1:0]    lane_p;
    logic [LW-1:0]    lane_res;
    logic [W-1:0]     sr_shift;
    logic             accept;
    logic             last_step;

    // P units always look at the lowest LANES bytes of the shift register.
    for (genvar l = 0; l < LANES_SAFE; l++) begin : g_lane
        p_module u_p (
            .x (sr[8*l +: 8]),
            .y (lane_p[8*l +: 8])
        );
    end

    assign lane_res = byp ? sr[LW-1:0] : lane_p;

    // Results enter at the top; after STEPS shifts every byte is back in its
    // original position. With a single step the whole word is replaced.
    if (STEPS == 1) begin : g_one_step
        assign sr_shift = lane_res;
    end else begin : g_multi_step
        assign sr_shift = {lane_res, sr[W-1:LW]};
    end

    assign last_step = (cnt == CNT_W'(STEPS - 1));
    assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                // Taking the result and a new word on the same edge keeps
                // throughput at one word per STEPS+1 cycles.
                if (out_ready) state_nxt = accept ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            byp       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == BUSY);
            if (accept) begin
                sr  <= in_data;
                byp <= in_bypass;
                cnt <= '0;
            end else if (state == BUSY) begin
                sr <= sr_shift;
                // Hold at the final value instead of wrapping.
                if (!last_step) cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out_data = sr;

endmodule

// File: tb/tb_p_layer_seq.sv
module tb_p_layer_seq;
    import p_table_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv;
    logic        ir;
    logic [63:0] id;
    logic        ib;
    logic        ov;
    logic        ordy;
    logic [63:0] od;
    logic        bsy;

    int   tests = 0;
    int   fails = 0;
    logic stream_go = 1'b0;

    p_layer_seq #(.NBYTES(8), .LANES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .in_data   (id),
        .in_bypass (ib),
        .out_valid (ov),
        .out_ready (ordy),
        .out_data  (od),
        .busy      (bsy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model8(input logic [63:0] d, input logic b);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = b ? d[8*i +: 8] : p_lookup(d[8*i +: 8]);
        return r;
    endfunction

    // Presents a word at a negedge, lets it be taken at the next edge, and
    // returns at the following negedge with in_valid dropped.
    task automatic send(input logic [63:0] d, input logic b);
        @(negedge clk);
        iv = 1'b1; id = d; ib = b;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
    endtask

    // Counts edges until out_valid, plus negedges with busy high on the way.
    task automatic wait_valid(output int lat, output int nbusy);
        lat = 0;
        nbusy = bsy ? 1 : 0;
        while (!ov && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bsy) nbusy++;
        end
    endtask

    // Streaming on several parameter sets, each running its own random traffic.
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int NB = (g == 3) ? 16 : 8;
        localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 4;

        logic            s_iv;
        logic            s_ir;
        logic [8*NB-1:0] s_id;
        logic            s_ib;
        logic            s_ov;
        logic            s_or;
        logic [8*NB-1:0] s_od;
        logic            s_busy;
        logic            s_done = 1'b0;

        p_layer_seq #(.NBYTES(NB), .LANES(LN)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .in_data   (s_id),
            .in_bypass (s_ib),
            .out_valid (s_ov),
            .out_ready (s_or),
            .out_data  (s_od),
            .busy      (s_busy)
        );

        initial begin : stream
            logic [8*NB-1:0] q[$];
            logic [8*NB-1:0] e;
            int sent;
            int got;
            int cyc;
            s_iv = 1'b0; s_id = '0; s_ib = 1'b0; s_or = 1'b1;
            wait (stream_go);
            sent = 0; got = 0; cyc = 0;
            while (got < 256 && cyc < 30000) begin
                @(negedge clk);
                cyc++;
                s_iv = (sent < 256) && ($urandom_range(3) != 0);
                s_ib = ($urandom_range(3) == 0);
                for (int b = 0; b < NB; b++) s_id[8*b +: 8] = 8'($urandom);
                s_or = ($urandom_range(2) != 0);
                #1;
                if (s_ov && s_or) begin
                    if (q.size() == 0) begin
                        check($sformatf("stream%0d_extra", g), 128'(got), 128'(sent));
                    end else begin
                        check($sformatf("stream%0d_word%0d", g, got), 128'(s_od), 128'(q.pop_front()));
                    end
                    got++;
                end
                if (s_iv && s_ir) begin
                    for (int b = 0; b < NB; b++)
                        e[8*b +: 8] = s_ib ? s_id[8*b +: 8] : p_lookup(s_id[8*b +: 8]);
                    q.push_back(e);
                    sent++;
                end
            end
            @(negedge clk);
            s_iv = 1'b0;
            check($sformatf("stream%0d_count", g), 128'(got), 128'd256);
            check($sformatf("stream%0d_left", g), 128'(q.size()), 128'd0);
            s_done = 1'b1;
        end
    end

    initial begin
        int lat;
        int nbusy;
        int spurious;
        logic [63:0] held;
        logic [63:0] w;

        rst_n = 1'b0; iv = 1'b0; id = '0; ib = 1'b0; ordy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(ov), 128'd0);
        check("rst_busy", 128'(bsy), 128'd0);
        check("rst_out_data", 128'(od), 128'd0);
        check("rst_in_ready", 128'(ir), 128'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 128'(ir), 128'd1);

        // Default word: identity bytes through P.
        w = 64'h0706050403020100;
        send(w, 1'b0);
        wait_valid(lat, nbusy);
        check("dflt_latency", 128'(lat), 128'd4);
        for (int i = 0; i < 8; i++)
            check($sformatf("dflt_byte%0d", i), 128'(od[8*i +: 8]), 128'(p_lookup(8'(i))));

        // Bypass word: unchanged, same latency and busy span.
        w = 64'hDEADBEEF01234567;
        send(w, 1'b1);
        wait_valid(lat, nbusy);
        check("byp_latency", 128'(lat), 128'd4);
        check("byp_busy_cycles", 128'(nbusy), 128'd4);
        check("byp_data", 128'(od), 128'(64'hDEADBEEF01234567));

        // Back-pressure in DONE.
        @(negedge clk);
        ordy = 1'b0;
        w = 64'h0123456789ABCDEF;
        send(w, 1'b0);
        wait_valid(lat, nbusy);
        check("bp_latency", 128'(lat), 128'd4);
        check("bp_data", 128'(od), 128'(model8(w, 1'b0)));
        held = od;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 128'(ov), 128'd1);
            check("bp_hold_data", 128'(od), 128'(held));
            check("bp_hold_in_ready", 128'(ir), 128'd0);
        end
        w = 64'hA5A55A5A00FF3C96;
        ordy = 1'b1; iv = 1'b1; id = w; ib = 1'b0;
        #1;
        check("bp_release_in_ready", 128'(ir), 128'd1);
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        check("bp_next_busy", 128'(bsy), 128'd1);
        check("bp_next_valid", 128'(ov), 128'd0);
        wait_valid(lat, nbusy);
        check("bp_next_latency", 128'(lat), 128'd4);
        check("bp_next_data", 128'(od), 128'(model8(w, 1'b0)));

        // Reset at step 2 discards the word in flight.
        send(64'h1122334455667788, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_out_valid", 128'(ov), 128'd0);
        check("abort_busy", 128'(bsy), 128'd0);
        check("abort_in_ready", 128'(ir), 128'd1);
        spurious = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov) spurious++;
        end
        check("abort_no_output", 128'(spurious), 128'd0);

        // Every byte value replicated across the word.
        for (int v = 0; v < 256; v++) begin
            w = {8{8'(v)}};
            send(w, 1'b0);
            wait_valid(lat, nbusy);
            check($sformatf("sweep_%02h", v), 128'(od), 128'({8{p_lookup(8'(v))}}));
        end

        stream_go = 1'b1;
        for (int k = 0; k < 40000; k++) begin
            if (g_cfg[0].s_done && g_cfg[1].s_done && g_cfg[2].s_done && g_cfg[3].s_done) break;
            @(posedge clk);
        end
        check("stream_all_done",
              128'({g_cfg[3].s_done, g_cfg[2].s_done, g_cfg[1].s_done, g_cfg[0].s_done}),
              128'(4'hF));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
